// File: rtl/dcache_2way_pkg.sv
// Shared definitions for the 2-way write-back data cache: FSM encoding and
// address-field width helpers derived from the set count and line width.
package dcache_2way_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MISS,
    ST_WRITEBACK,
    ST_REFILL,
    ST_REFILL_DONE
  } state_e;

  function automatic int off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets, input int line_w);
    return 32 - idx_w(sets) - off_w(line_w);
  endfunction

endpackage

// File: rtl/dcache_2way_if.sv
// Line-wide memory bus between the cache (master) and main memory (slave).
interface dcache_2way_if #(
  parameter int LINE_W = 256
);
  // Handshake: the master raises enable (with write, addr, wdata stable) and
  // holds it until the slave returns a single-cycle ack; rdata is valid with ack.
  logic [31:0]       addr;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              enable;
  logic              write;
  logic              ack;

  modport master (output addr, wdata, enable, write, input rdata, ack);
  modport slave  (input addr, wdata, enable, write, output rdata, ack);
endinterface

// File: rtl/dcache_2way_way.sv
// One cache way: valid/dirty/tag/line storage per set with a synchronous
// write port and a combinational read at the same index.
module dcache_way
  import dcache_2way_pkg::*;
#(
  parameter int SETS   = 32,
  parameter int LINE_W = 256,
  localparam int IDX_W = idx_w(SETS),
  localparam int TAG_W = tag_w(SETS, LINE_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              dirty_i,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [LINE_W-1:0] line_o
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] line_q [SETS];

  // Only the status bits need reset; tag/data contents are don't-care until valid.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= dirty_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[idx_i]  <= tag_i;
      line_q[idx_i] <= line_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = line_q[idx_i];

endmodule

// File: rtl/dcache_2way.sv
// 2-way set-associative, write-back, write-allocate data cache with one LRU
// bit per set and a blocking miss FSM talking to a line-wide memory.
module dcache_2way
  import dcache_2way_pkg::*;
#(
  parameter int SETS   = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output state_e            dbg_state_o
);

  localparam int OFF_W  = off_w(LINE_W);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(SETS, LINE_W);
  localparam int WORDS  = LINE_W / 32;
  localparam int WORD_W = OFF_W - 2;

  logic [TAG_W-1:0]  p1_tag;
  logic [IDX_W-1:0]  p1_idx;
  logic [WORD_W-1:0] p1_word;
  logic              unused_addr_bits;

  assign p1_tag           = p1_addr_i[31 -: TAG_W];
  assign p1_idx           = p1_addr_i[OFF_W +: IDX_W];
  assign p1_word          = p1_addr_i[2 +: WORD_W];
  assign unused_addr_bits = ^p1_addr_i[1:0];

  state_e           state_q, state_d;
  logic             victim_q, victim_d;
  logic [TAG_W-1:0] miss_tag_q;
  logic [IDX_W-1:0] miss_idx_q;
  logic [SETS-1:0]  lru_q;

  logic [1:0]        way_we, way_valid, way_dirty, way_hit;
  logic [TAG_W-1:0]  way_tag  [2];
  logic [LINE_W-1:0] way_line [2];
  logic [IDX_W-1:0]  way_idx;
  logic [TAG_W-1:0]  way_wtag;
  logic [LINE_W-1:0] way_wline;
  logic              way_wdirty;

  logic              req, is_idle, hit, hit_way, wr_hit, refill_we;
  logic [LINE_W-1:0] hit_line, merged_line;
  logic [31:0]       hit_word;

  assign req       = p1_MemRead_i | p1_MemWrite_i;
  assign is_idle   = (state_q == ST_IDLE);
  assign way_hit   = {way_valid[1] && (way_tag[1] == p1_tag),
                      way_valid[0] && (way_tag[0] == p1_tag)};
  assign hit       = req && is_idle && (|way_hit);
  assign hit_way   = way_hit[1];
  assign hit_line  = way_line[hit_way];
  assign wr_hit    = hit && p1_MemWrite_i;
  assign refill_we = (state_q == ST_REFILL) && mem_ack_i;

  // Lookups use the CPU index when idle and the latched miss index otherwise,
  // so a request that drops mid-miss still refills the right set.
  assign way_idx    = is_idle ? p1_idx : miss_idx_q;
  assign way_wtag   = refill_we ? miss_tag_q : p1_tag;
  assign way_wline  = refill_we ? mem_data_i : merged_line;
  assign way_wdirty = !refill_we;
  assign way_we[0]  = (refill_we && !victim_q) || (wr_hit && way_hit[0]);
  assign way_we[1]  = (refill_we &&  victim_q) || (wr_hit && way_hit[1]);

  for (genvar w = 0; w < 2; w++) begin : g_way
    dcache_way #(.SETS(SETS), .LINE_W(LINE_W)) u_way (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (way_we[w]),
      .idx_i   (way_idx),
      .tag_i   (way_wtag),
      .line_i  (way_wline),
      .dirty_i (way_wdirty),
      .valid_o (way_valid[w]),
      .dirty_o (way_dirty[w]),
      .tag_o   (way_tag[w]),
      .line_o  (way_line[w])
    );
  end

  always_comb begin
    hit_word    = '0;
    merged_line = hit_line;
    for (int w = 0; w < WORDS; w++) begin
      if (WORD_W'(w) == p1_word) begin
        hit_word            = hit_line[w*32 +: 32];
        merged_line[w*32 +: 32] = p1_data_i;
      end
    end
  end

  always_comb begin
    victim_d = lru_q[p1_idx];
    if (!way_valid[0])      victim_d = 1'b0;
    else if (!way_valid[1]) victim_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      victim_q   <= 1'b0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      lru_q      <= '0;
    end else begin
      if (is_idle && req && !hit) begin
        victim_q   <= victim_d;
        miss_tag_q <= p1_tag;
        miss_idx_q <= p1_idx;
      end
      if (hit) lru_q[p1_idx] <= !hit_way;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:        if (req && !hit) state_d = ST_MISS;
      ST_MISS:        state_d = (way_valid[victim_q] && way_dirty[victim_q]) ? ST_WRITEBACK : ST_REFILL;
      ST_WRITEBACK:   if (mem_ack_i) state_d = ST_REFILL;
      ST_REFILL:      if (mem_ack_i) state_d = ST_REFILL_DONE;
      ST_REFILL_DONE: state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_enable_o = (state_q == ST_WRITEBACK) || (state_q == ST_REFILL);
    mem_write_o  = (state_q == ST_WRITEBACK);
    mem_addr_o   = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
    if (state_q == ST_WRITEBACK) mem_addr_o = {way_tag[victim_q], miss_idx_q, {OFF_W{1'b0}}};
    mem_data_o   = way_line[victim_q];
    p1_stall_o   = req && !hit;
    p1_data_o    = (hit && !p1_MemWrite_i) ? hit_word : 32'h0;
  end

  assign dbg_state_o = state_q;

  a_single_way_hit: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(req && is_idle && (&way_hit)))
    else $error("both ways hit for one address");

endmodule

// File: doc/dcache_2way.md
DCACHE_2WAY -- requirements
Module: dcache_2way

Interface
REQ-001 Parameter SETS, default 32: number of sets, a power of two of at least 2.
REQ-002 Parameter LINE_W, default 256: line width in bits, a power of two, 64 to 1024.
REQ-003 Parameters derived: OFF_W = log2(LINE_W/8); IDX_W = log2(SETS); TAG_W = 32-IDX_W-OFF_W.
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-low.
REQ-006 p1_addr_i  in  32  CPU byte address; bits [1:0] are ignored.
REQ-007 p1_data_i  in  32  CPU write data.
REQ-008 p1_MemRead_i / p1_MemWrite_i  in  1 each  request strobes; if both are high, the request is a write.
REQ-009 p1_data_o  out  32  read data; 0 when there is no read hit.
REQ-010 p1_stall_o  out  1  high while a request is pending and misses.
REQ-011 mem_addr_o  out  32  line-aligned memory address.
REQ-012 mem_data_o  out  LINE_W  write-back line.
REQ-013 mem_enable_o / mem_write_o  out  1 each  memory request and write qualifier.
REQ-014 mem_data_i  in  LINE_W  refill line.
REQ-015 mem_ack_i  in  1  single-cycle completion pulse.

Function
REQ-016 Organisation: 2-way set associative, write-back, write-allocate; per way and set: valid, dirty, tag, line; one LRU bit per set.
REQ-017 Address split: tag = addr[31:OFF_W+IDX_W]; index = addr[OFF_W+IDX_W-1:OFF_W]; word = addr[OFF_W-1:2].
REQ-018 Hit condition: a request is present, the FSM is in IDLE, and either way is valid with a matching tag; both ways matching is illegal and is asserted.
REQ-019 Read hit: p1_data_o is the selected word, combinational in the same cycle; p1_stall_o = 0.
REQ-020 Write hit: on the next edge, the word is written and the way's dirty bit is set; p1_stall_o = 0.
REQ-021 Any hit: on the next edge, LRU[set] is set to point at the way that was not hit.
REQ-022 Victim choice on a miss: the first invalid way (way0 preferred); if both ways are valid, the way given by LRU[set].
REQ-023 p1_stall_o = request & ~hit, in all states.
REQ-024 FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE.
REQ-025 IDLE -> MISS on a request that misses; the victim way is latched at this transition.
REQ-026 MISS -> WRITEBACK if the victim is valid and dirty, otherwise MISS -> REFILL; mem_enable_o rises on this transition.
REQ-027 WRITEBACK: mem_write_o = 1; mem_addr_o = {victim tag, index, 0}; mem_data_o = victim line; on mem_ack_i -> REFILL, with mem_enable_o held high.
REQ-028 REFILL: mem_write_o = 0; mem_addr_o = {p1 tag, index, 0}; on mem_ack_i, the victim is written with mem_data_i, valid = 1, dirty = 0, and the state moves to REFILL_DONE with mem_enable_o = 0.
REQ-029 REFILL_DONE -> IDLE unconditionally; the request is then re-evaluated and hits, and a write is merged at that point.
REQ-030 Latency: a clean miss stalls for 3 cycles plus the memory latency; a dirty miss adds the write-back latency.
REQ-031 The CPU holds address, data and strobes stable while stalled; if the request drops mid-miss, the refill still completes and the FSM returns to IDLE.
REQ-032 mem_ack_i outside WRITEBACK or REFILL is ignored.

Reset
REQ-033 On rst_i low: state = IDLE; all valid, dirty and LRU bits = 0; mem_enable_o, mem_write_o = 0; tag and data contents are don't-care.
REQ-034 Reset mid-miss aborts the transfer immediately with no cache update; the memory model discards the partial transaction.

Structure
REQ-035 A shared package holds the FSM state encoding and the derived width functions (OFF_W, IDX_W, TAG_W).
REQ-036 Sub-module dcache_way is instantiated twice; it holds the valid, dirty, tag and data arrays for one way, with a synchronous write port and combinational read.
REQ-037 The top level holds the LRU array, the hit/victim logic, the FSM and the word select/merge logic.

Verification
REQ-038 Cold read of 0x0000_0400 (SETS=32, LINE_W=256) -> one refill read at 0x400; 0 -> way0; the result is returned after REFILL_DONE.
REQ-039 Reads of 0x400 then 0x800 (same set 0, different tags) -> the second fills way1; a re-read of 0x400 hits with no memory access.
REQ-040 Write 0xDEADBEEF to 0x404, read 0x400 and then 0xC00 -> 0xC00 evicts way1 (the LRU way); no write-back occurs because 0x800 is clean.
REQ-041 Write 0x12345678 to 0x800 (dirty), then touch 0x400, then read 0x1000 -> write-back of line 0x800 with word0 = 0x12345678, then refill at 0x1000.
REQ-042 Assert rst_i during REFILL, then read 0x400 -> miss with a fresh refill; no stale hit.
